// File: rtl/dcache_assoc.sv
// dcache_assoc: write-back / write-allocate data cache, 1 or 2 ways, 1-bit LRU per set when 2-way.
// Define DCACHE_STATS_EN to add saturating hit / miss / writeback counters (stat_*_o).
module dcache_assoc #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LINE_W = 256,
    parameter int SETS   = 32,
    parameter int WAYS   = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] p1_data_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic              p1_MemRead_i,
    input  logic              p1_MemWrite_i,
    output logic [DATA_W-1:0] p1_data_o,
    output logic              p1_stall_o,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i,
    output logic [LINE_W-1:0] mem_data_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_enable_o,
    output logic              mem_write_o
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]       stat_hit_o,
    output logic [31:0]       stat_miss_o,
    output logic [31:0]       stat_wb_o
`endif
);

    localparam int OFF      = $clog2(LINE_W / 8);
    localparam int BYTE_OFF = $clog2(DATA_W / 8);
    localparam int WSEL_W   = OFF - BYTE_OFF;
    localparam int IDX_W    = $clog2(SETS);
    localparam int TAG_W    = ADDR_W - OFF - IDX_W;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WB    = 2'd1;
    localparam logic [1:0] S_ALLOC = 2'd2;

    logic [1:0]              state_q, state_d;
    logic                    victim_q, victim_d;
    logic                    mem_enable_q, mem_enable_d;
    logic                    mem_write_q, mem_write_d;
    logic [ADDR_W-1:0]       mem_addr_q, mem_addr_d;
    logic [LINE_W-1:0]       mem_data_q, mem_data_d;

    logic [WAYS-1:0][SETS-1:0] valid_q, valid_d;
    logic [WAYS-1:0][SETS-1:0] dirty_q, dirty_d;
    logic [TAG_W-1:0]        tag_q  [WAYS][SETS];
    logic [LINE_W-1:0]       line_q [WAYS][SETS];

    logic [IDX_W-1:0]        idx;
    logic [TAG_W-1:0]        req_tag;
    logic [WSEL_W-1:0]       wsel;
    logic                    req, is_write;
    logic [WAYS-1:0]         hit_vec;
    logic                    hit, hit_way, victim_sel, lru_way;
    logic [LINE_W-1:0]       hit_line;
    logic [ADDR_W-1:0]       req_line_addr, victim_addr;

    logic                    line_we, line_way, tag_we, lru_we, lru_way_wr;
    logic [LINE_W-1:0]       line_wdata;

    logic                    unused_addr_bits;
    assign unused_addr_bits = ^p1_addr_i[BYTE_OFF-1:0];

    assign idx      = p1_addr_i[OFF +: IDX_W];
    assign req_tag  = p1_addr_i[ADDR_W-1 -: TAG_W];
    assign wsel     = p1_addr_i[BYTE_OFF +: WSEL_W];
    assign req      = p1_MemRead_i | p1_MemWrite_i;
    assign is_write = p1_MemWrite_i;

    always_comb begin
        hit_vec = '0;
        hit_way = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            hit_vec[w] = valid_q[w][idx] && (tag_q[w][idx] == req_tag);
            if (hit_vec[w]) hit_way = 1'(w);
        end
    end

    // Invalid ways are filled before anything is evicted, lowest way first.
    always_comb begin
        victim_sel = lru_way;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[w][idx]) victim_sel = 1'(w);
        end
    end

    assign hit           = |hit_vec;
    assign hit_line      = line_q[hit_way][idx];
    assign req_line_addr = {req_tag, idx, {OFF{1'b0}}};
    assign victim_addr   = {tag_q[victim_sel][idx], idx, {OFF{1'b0}}};

    assign p1_data_o  = (hit && p1_MemRead_i && !p1_MemWrite_i) ? hit_line[wsel*DATA_W +: DATA_W] : '0;
    assign p1_stall_o = (state_q != S_IDLE) || (req && !hit);

    assign mem_enable_o = mem_enable_q;
    assign mem_write_o  = mem_write_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_data_o   = mem_data_q;

    always_comb begin
        state_d      = state_q;
        victim_d     = victim_q;
        mem_enable_d = mem_enable_q;
        mem_write_d  = mem_write_q;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;
        valid_d      = valid_q;
        dirty_d      = dirty_q;
        line_we      = 1'b0;
        line_way     = hit_way;
        line_wdata   = hit_line;
        tag_we       = 1'b0;
        lru_we       = 1'b0;
        lru_way_wr   = hit_way;
        case (state_q)
            S_IDLE: begin
                if (req && hit) begin
                    lru_we = 1'b1;
                    if (is_write) begin
                        line_we = 1'b1;
                        line_wdata[wsel*DATA_W +: DATA_W] = p1_data_i;
                        dirty_d[hit_way][idx] = 1'b1;
                    end
                end else if (req) begin
                    victim_d     = victim_sel;
                    mem_enable_d = 1'b1;
                    if (valid_q[victim_sel][idx] && dirty_q[victim_sel][idx]) begin
                        state_d     = S_WB;
                        mem_write_d = 1'b1;
                        mem_addr_d  = victim_addr;
                        mem_data_d  = line_q[victim_sel][idx];
                    end else begin
                        state_d     = S_ALLOC;
                        mem_write_d = 1'b0;
                        mem_addr_d  = req_line_addr;
                    end
                end
            end
            S_WB: begin
                if (mem_ack_i) begin
                    state_d     = S_ALLOC;
                    mem_write_d = 1'b0;
                    mem_addr_d  = req_line_addr;
                end
            end
            S_ALLOC: begin
                // The pipeline is stalled, so p1_addr_i still names the missing line here.
                if (mem_ack_i) begin
                    state_d                = S_IDLE;
                    mem_enable_d           = 1'b0;
                    line_we                = 1'b1;
                    line_way               = victim_q;
                    line_wdata             = mem_data_i;
                    tag_we                 = 1'b1;
                    valid_d[victim_q][idx] = 1'b1;
                    dirty_d[victim_q][idx] = 1'b0;
                    lru_we                 = 1'b1;
                    lru_way_wr             = victim_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            victim_q     <= 1'b0;
            mem_enable_q <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            valid_q      <= '0;
            dirty_q      <= '0;
        end else begin
            state_q      <= state_d;
            victim_q     <= victim_d;
            mem_enable_q <= mem_enable_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            valid_q      <= valid_d;
            dirty_q      <= dirty_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (line_we) line_q[line_way][idx] <= line_wdata;
        if (tag_we)  tag_q[victim_q][idx]  <= req_tag;
    end

    // lru names the way to evict next, i.e. the way not touched most recently.
    generate
        if (WAYS == 2) begin : g_lru
            logic [SETS-1:0] lru_q, lru_d;
            always_comb begin
                lru_d = lru_q;
                if (lru_we) lru_d[idx] = ~lru_way_wr;
            end
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) lru_q <= '0;
                else       lru_q <= lru_d;
            end
            assign lru_way = lru_q[idx];
        end else begin : g_no_lru
            logic unused_lru;
            assign unused_lru = ^{lru_we, lru_way_wr};
            assign lru_way    = 1'b0;
        end
    endgenerate

`ifdef DCACHE_STATS_EN
    logic        replay_q, replay_d;
    logic [31:0] stat_hit_q, stat_hit_d;
    logic [31:0] stat_miss_q, stat_miss_d;
    logic [31:0] stat_wb_q, stat_wb_d;

    always_comb begin
        replay_d    = (state_q == S_ALLOC) && mem_ack_i;
        stat_hit_d  = stat_hit_q;
        stat_miss_d = stat_miss_q;
        stat_wb_d   = stat_wb_q;
        if ((state_q == S_IDLE) && req && hit && !replay_q && (stat_hit_q != '1))
            stat_hit_d = stat_hit_q + 32'd1;
        if ((state_q == S_IDLE) && req && !hit && (stat_miss_q != '1))
            stat_miss_d = stat_miss_q + 32'd1;
        if ((state_q == S_WB) && mem_ack_i && (stat_wb_q != '1))
            stat_wb_d = stat_wb_q + 32'd1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            replay_q    <= 1'b0;
            stat_hit_q  <= '0;
            stat_miss_q <= '0;
            stat_wb_q   <= '0;
        end else begin
            replay_q    <= replay_d;
            stat_hit_q  <= stat_hit_d;
            stat_miss_q <= stat_miss_d;
            stat_wb_q   <= stat_wb_d;
        end
    end

    assign stat_hit_o  = stat_hit_q;
    assign stat_miss_o = stat_miss_q;
    assign stat_wb_o   = stat_wb_q;
`endif

endmodule

// File: tb/tb_dcache_assoc.sv
// tb_dcache_assoc: directed and random accesses against a recency-list cache model and a line memory.
// The memory responder acks four cycles after it sees a request.
module tb_dcache_assoc;

    localparam int SETS = 32;
    localparam int WAYS = 2;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic [31:0]  p1_data_i;
    logic [31:0]  p1_addr_i;
    logic         p1_MemRead_i;
    logic         p1_MemWrite_i;
    logic [31:0]  p1_data_o;
    logic         p1_stall_o;
    logic [255:0] mem_data_i;
    logic         mem_ack_i;
    logic [255:0] mem_data_o;
    logic [31:0]  mem_addr_o;
    logic         mem_enable_o;
    logic         mem_write_o;
`ifdef DCACHE_STATS_EN
    logic [31:0]  stat_hit_o, stat_miss_o, stat_wb_o;
`endif

    dcache_assoc #(.ADDR_W(32), .DATA_W(32), .LINE_W(256), .SETS(SETS), .WAYS(WAYS)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .p1_data_i(p1_data_i), .p1_addr_i(p1_addr_i),
        .p1_MemRead_i(p1_MemRead_i), .p1_MemWrite_i(p1_MemWrite_i),
        .p1_data_o(p1_data_o), .p1_stall_o(p1_stall_o),
        .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
        .mem_data_o(mem_data_o), .mem_addr_o(mem_addr_o),
        .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o)
`ifdef DCACHE_STATS_EN
        , .stat_hit_o(stat_hit_o), .stat_miss_o(stat_miss_o), .stat_wb_o(stat_wb_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    // Transactions are {write, line address, writeback data (0 for refills)}.
    logic [288:0] exp_q[$];
    logic [288:0] obs_q[$];
    logic [255:0] last_wb;

    logic [255:0] backing [logic [31:0]];
    logic [255:0] mmem    [logic [31:0]];
    logic [255:0] cline   [logic [31:0]];
    bit           cdirty  [logic [31:0]];
    logic [31:0]  res     [SETS][$];

    function automatic logic [255:0] init_line(input logic [31:0] la);
        logic [255:0] l;
        for (int w = 0; w < 8; w++) l[w*32 +: 32] = ((la + 32'(w * 4)) * 32'h9E3779B1) ^ 32'h5A5A1234;
        if (la == 32'h40) l[31:0] = 32'h11111111;
        return l;
    endfunction

    function automatic logic [255:0] mmem_rd(input logic [31:0] la);
        return mmem.exists(la) ? mmem[la] : init_line(la);
    endfunction

    task automatic chk(input string tag, input logic [288:0] obs, input logic [288:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Memory responder, driven on the falling edge so the cache samples stable values.
    initial begin : responder
        int cnt;
        logic [31:0] la;
        cnt = 0;
        mem_ack_i  = 1'b0;
        mem_data_i = '0;
        forever begin
            @(negedge clk_i);
            if (rst_i === 1'b1 || mem_ack_i) begin
                mem_ack_i = 1'b0;
                cnt = 0;
            end else if (mem_enable_o === 1'b1) begin
                cnt++;
                if (cnt == 4) begin
                    cnt = 0;
                    mem_ack_i = 1'b1;
                    la = mem_addr_o;
                    if (mem_write_o) begin
                        backing[la] = mem_data_o;
                        obs_q.push_back({1'b1, la, mem_data_o});
                    end else begin
                        mem_data_i = backing.exists(la) ? backing[la] : init_line(la);
                        obs_q.push_back({1'b0, la, 256'b0});
                    end
                end
            end else begin
                cnt = 0;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic model_reset();
        for (int i = 0; i < SETS; i++) res[i].delete();
        cline.delete();
        cdirty.delete();
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        p1_MemRead_i = 1'b0;
        p1_MemWrite_i = 1'b0;
        #1;
        chk("rst_mem_enable", mem_enable_o, 0);
        chk("rst_mem_write", mem_write_o, 0);
        chk("rst_mem_addr", mem_addr_o, 0);
        chk("rst_mem_data", mem_data_o, 0);
        chk("rst_stall", p1_stall_o, 0);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        model_reset();
    endtask

    // One CPU access; starts and ends on a falling edge.
    task automatic access(input bit rd, input bit wr, input logic [31:0] addr, input logic [31:0] wd);
        int set, pos, n, exp_n;
        logic [31:0] la, v, exp_rd;
        logic [255:0] ln;
        logic [288:0] e, o;
        bit hit;
        set = int'(addr[9:5]);
        la  = {addr[31:5], 5'b0};
        pos = -1;
        for (int i = 0; i < res[set].size(); i++) if (res[set][i] == la) pos = i;
        hit = (pos >= 0);
        exp_n = 0;
        if (hit) begin
            res[set].delete(pos);
        end else begin
            exp_n = 5;
            if (res[set].size() == WAYS) begin
                v = res[set].pop_back();
                if (cdirty[v]) begin
                    exp_q.push_back({1'b1, v, cline[v]});
                    mmem[v] = cline[v];
                    exp_n = 10;
                end
                cline.delete(v);
                cdirty.delete(v);
            end
            exp_q.push_back({1'b0, la, 256'b0});
            cline[la]  = mmem_rd(la);
            cdirty[la] = 1'b0;
        end
        res[set].push_front(la);
        ln = cline[la];
        exp_rd = (rd && !wr) ? ln[addr[4:2]*32 +: 32] : 32'h0;
        if (wr) begin
            ln[addr[4:2]*32 +: 32] = wd;
            cline[la]  = ln;
            cdirty[la] = 1'b1;
        end

        p1_addr_i = addr;
        p1_MemRead_i = rd;
        p1_MemWrite_i = wr;
        p1_data_i = wd;
        #1;
        chk("stall_on_request", p1_stall_o, !hit);
        n = 0;
        while (p1_stall_o !== 1'b0 && n < 40) begin
            @(negedge clk_i);
            #1;
            n++;
        end
        chk("stall_cycles", n, exp_n);
        chk("load_data", p1_data_o, exp_rd);
        chk("mem_enable_after", mem_enable_o, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() == 0) ? '1 : obs_q.pop_front();
            if (e[288]) last_wb = o[255:0];
            chk("mem_txn", o, e);
        end
        chk("no_extra_txn", obs_q.size(), 0);
        obs_q.delete();
        @(negedge clk_i);
        p1_MemRead_i = 1'b0;
        p1_MemWrite_i = 1'b0;
    endtask

    initial begin : main
        logic [31:0] addr;
        int r;
        rst_i = 1'b1;
        p1_addr_i = '0;
        p1_data_i = '0;
        p1_MemRead_i = 1'b0;
        p1_MemWrite_i = 1'b0;
        last_wb = '0;
        do_reset();

        // Cold refill, hit write, dirty eviction.
        access(1'b1, 1'b0, 32'h0000_0040, 32'h0);
        access(1'b0, 1'b1, 32'h0000_0044, 32'hDEADBEEF);
        access(1'b1, 1'b0, 32'h0000_0044, 32'h0);
        access(1'b1, 1'b0, 32'h0000_0440, 32'h0);
        access(1'b1, 1'b0, 32'h0000_0840, 32'h0);
        chk("wb_word1", last_wb[63:32], 32'hDEADBEEF);

        // LRU: re-touching 0x040 makes 0x440 the eviction victim.
        do_reset();
        access(1'b1, 1'b0, 32'h0000_0040, 32'h0);
        access(1'b1, 1'b0, 32'h0000_0440, 32'h0);
        access(1'b1, 1'b0, 32'h0000_0040, 32'h0);
        access(1'b1, 1'b0, 32'h0000_0840, 32'h0);
`ifdef DCACHE_STATS_EN
        chk("stat_miss", stat_miss_o, 3);
        chk("stat_hit", stat_hit_o, 1);
        chk("stat_wb", stat_wb_o, 0);
`endif
        access(1'b1, 1'b0, 32'h0000_0040, 32'h0);

        // Reset while a refill is outstanding.
        do_reset();
        p1_addr_i = 32'h0000_0040;
        p1_MemRead_i = 1'b1;
        #1;
        chk("abort_stall_req", p1_stall_o, 1);
        repeat (2) @(negedge clk_i);
        #1;
        chk("abort_enable_before", mem_enable_o, 1);
        chk("abort_addr_before", mem_addr_o, 32'h40);
        rst_i = 1'b1;
        #1;
        chk("abort_enable_after", mem_enable_o, 0);
        chk("abort_addr_after", mem_addr_o, 0);
        chk("abort_stall_miss", p1_stall_o, 1);
        p1_MemRead_i = 1'b0;
        #1;
        chk("abort_stall_idle", p1_stall_o, 0);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        model_reset();
        access(1'b1, 1'b0, 32'h0000_0040, 32'h0);

        // Random traffic over a few sets and tags to force conflicts and evictions.
        for (int k = 0; k < 300; k++) begin
            r = $urandom_range(0, 9);
            addr = 32'h0;
            addr[12:10] = 3'($urandom_range(0, 7));
            addr[6:5]   = 2'($urandom_range(0, 3));
            addr[4:2]   = 3'($urandom_range(0, 7));
            access((r < 5) || (r == 9), r >= 5, addr, $urandom());
            repeat ($urandom_range(0, 2)) @(negedge clk_i);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
